// File: rtl/mem_fetch_unit_if.sv
// Bus bundle for mem_fetch_unit: request/control inputs from the core,
// the memory read port, and the fetch/load results.
// The master side drives requests and memory responses.
// The slave side is the fetch unit itself.
interface mem_fetch_unit_if;
  // core-side request and control
  logic        fetch;
  logic        load;
  logic [15:0] aluo;
  logic        pcw;
  logic [15:0] pc_in;
  // memory response
  logic        mem_ack;
  logic [15:0] mem_rdata;
  // unit outputs
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] md;
  logic        iw;
  logic [15:0] pc;
  logic        busy;
  logic        done;
  logic        fault;

  modport master (
    output fetch, load, aluo, pcw, pc_in, mem_ack, mem_rdata,
    input  mem_addr, mem_rd, md, iw, pc, busy, done, fault
  );

  modport slave (
    input  fetch, load, aluo, pcw, pc_in, mem_ack, mem_rdata,
    output mem_addr, mem_rd, md, iw, pc, busy, done, fault
  );
endinterface

// File: rtl/mem_fetch_unit.sv
// Memory fetch unit: owns the program counter and issues one outstanding
// memory read at a time, either an instruction fetch (address = PC) or a
// data load (address = ALU result). Read data lands in MD. Instruction
// completion pulses IW and advances PC by 2. A request that sees no
// acknowledge for 16 cycles is abandoned and sets a sticky Fault flag.
module mem_fetch_unit (
  input logic             i_clk,
  input logic             i_rst,
  mem_fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IREQ = 2'd1,
    ST_DREQ = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_md;
  logic [15:0] r_mem_addr;
  logic        r_mem_rd;
  logic        r_iw;
  logic        r_done;
  logic        r_busy;
  logic        r_fault;
  logic [3:0]  r_tmo_cnt;

  logic [15:0] w_pc_inc;
  logic        w_tmo_hit;

  // PC+2 wraps naturally at 16 bits (0xFFFE -> 0x0000).
  assign w_pc_inc  = r_pc + 16'd2;
  // 15 ack-less edges already counted, so the current edge is the 16th.
  assign w_tmo_hit = (r_tmo_cnt == 4'd15);

  // Request FSM with PC, MD, strobe and pulse registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= 16'h0000;
      r_md       <= 16'h0000;
      r_mem_addr <= 16'h0000;
      r_mem_rd   <= 1'b0;
      r_iw       <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_fault    <= 1'b0;
      r_tmo_cnt  <= 4'd0;
    end else begin
      // Completion pulses last a single cycle unless re-armed below.
      r_iw   <= 1'b0;
      r_done <= 1'b0;

      // An explicit PC write always wins, including over PC+2 on fetch completion.
      if (bus.pcw) begin
        r_pc <= bus.pc_in;
      end else begin
        r_pc <= r_pc;
      end

      case (r_state)
        ST_IDLE: begin
          // Fetch has priority; a simultaneous Load is simply dropped.
          if (bus.fetch) begin
            r_mem_addr <= r_pc;
            r_mem_rd   <= 1'b1;
            r_busy     <= 1'b1;
            r_tmo_cnt  <= 4'd0;
            r_state    <= ST_IREQ;
          end else if (bus.load) begin
            r_mem_addr <= bus.aluo;
            r_mem_rd   <= 1'b1;
            r_busy     <= 1'b1;
            r_tmo_cnt  <= 4'd0;
            r_state    <= ST_DREQ;
          end else begin
            r_state    <= ST_IDLE;
          end
        end

        ST_IREQ: begin
          if (bus.mem_ack) begin
            r_md     <= bus.mem_rdata;
            r_iw     <= 1'b1;
            r_done   <= 1'b1;
            r_mem_rd <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
            if (!bus.pcw) begin
              r_pc <= w_pc_inc;
            end else begin
              r_pc <= bus.pc_in;
            end
          end else if (w_tmo_hit) begin
            r_mem_rd  <= 1'b0;
            r_busy    <= 1'b0;
            r_fault   <= 1'b1;
            r_tmo_cnt <= 4'd0;
            r_state   <= ST_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 4'd1;
          end
        end

        ST_DREQ: begin
          if (bus.mem_ack) begin
            r_md     <= bus.mem_rdata;
            r_done   <= 1'b1;
            r_mem_rd <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end else if (w_tmo_hit) begin
            r_mem_rd  <= 1'b0;
            r_busy    <= 1'b0;
            r_fault   <= 1'b1;
            r_tmo_cnt <= 4'd0;
            r_state   <= ST_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 4'd1;
          end
        end

        default: begin
          // Unreachable encoding: fall back to a quiet idle.
          r_mem_rd  <= 1'b0;
          r_busy    <= 1'b0;
          r_tmo_cnt <= 4'd0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_rd   = r_mem_rd;
  assign bus.md       = r_md;
  assign bus.iw       = r_iw;
  assign bus.pc       = r_pc;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.fault    = r_fault;

endmodule

// File: tb/tb_mem_fetch_unit.sv
// Self-checking bench for mem_fetch_unit. A transaction-level model tracks
// PC, MD and Fault; each request's expected address, strobe length and
// pulses follow directly from its kind and acknowledge delay.
module tb_mem_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [15:0] m_pc    = 16'h0000;
  logic [15:0] m_md    = 16'h0000;
  logic        m_fault = 1'b0;

  mem_fetch_unit_if bus ();

  mem_fetch_unit dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from idle and watch it to completion plus two idle cycles.
  // waits >= 16 means memory never acknowledges.
  task automatic drive_txn(input bit f, input bit l, input logic [15:0] a, input int waits,
                           input logic [15:0] d, input bit pcw_ack, input logic [15:0] pcv,
                           input bit churn, output logic [15:0] o_addr, output int o_rd,
                           output int o_iw, output int o_done, output bit o_stable);
    int end_i;
    end_i = (waits < 16) ? waits : 15;
    bus.fetch = f; bus.load = l; bus.aluo = a;
    tick();
    o_addr = bus.mem_addr; o_rd = bus.mem_rd ? 1 : 0; o_iw = 0; o_done = 0; o_stable = 1'b1;
    for (int i = 0; i < end_i + 3; i++) begin
      if (churn && i <= end_i) begin
        bus.fetch = 1'($urandom_range(0, 1));
        bus.load  = 1'($urandom_range(0, 1));
        bus.aluo  = 16'($urandom);
      end else begin
        bus.fetch = 1'b0; bus.load = 1'b0;
      end
      bus.mem_ack   = (i == waits);
      bus.mem_rdata = (i == waits) ? d : 16'($urandom);
      bus.pcw       = (i == waits) && pcw_ack;
      bus.pc_in     = pcv;
      tick();
      if (bus.mem_rd) o_rd++;
      if (bus.iw) o_iw++;
      if (bus.done) o_done++;
      if (bus.mem_rd && bus.mem_addr !== o_addr) o_stable = 1'b0;
    end
    bus.mem_ack = 1'b0; bus.pcw = 1'b0; bus.fetch = 1'b0; bus.load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    total++; if (bus.pc !== 16'h0000) begin bad++; $display("FAIL rst_pc got=%h exp=0000", bus.pc); end
    total++; if (bus.md !== 16'h0000) begin bad++; $display("FAIL rst_md got=%h exp=0000", bus.md); end
    total++; if (bus.mem_addr !== 16'h0000) begin bad++; $display("FAIL rst_addr got=%h exp=0000", bus.mem_addr); end
    total++; if ({bus.mem_rd, bus.iw, bus.busy, bus.done, bus.fault} !== 5'b00000) begin
      bad++; $display("FAIL rst_flags got=%b exp=00000", {bus.mem_rd, bus.iw, bus.busy, bus.done, bus.fault});
    end
    rst = 1'b0;
    tick();
    m_pc = 16'h0000; m_md = 16'h0000; m_fault = 1'b0;
  endtask

  task automatic test_fetch_basic();
    logic [15:0] ad; int rd, iw, dn; bit st;
    drive_txn(1'b1, 1'b0, 16'h1234, 0, 16'h0127, 1'b0, 16'h0000, 1'b0, ad, rd, iw, dn, st);
    m_md = 16'h0127; m_pc = m_pc + 16'd2;
    total++; if (ad !== 16'h0000) begin bad++; $display("FAIL basic_addr got=%h exp=0000", ad); end
    total++; if (rd != 1) begin bad++; $display("FAIL basic_rd_cycles got=%0d exp=1", rd); end
    total++; if (iw != 1 || dn != 1) begin bad++; $display("FAIL basic_pulses got iw=%0d done=%0d exp=1/1", iw, dn); end
    total++; if (bus.md !== m_md) begin bad++; $display("FAIL basic_md got=%h exp=%h", bus.md, m_md); end
    total++; if (bus.pc !== m_pc) begin bad++; $display("FAIL basic_pc got=%h exp=%h", bus.pc, m_pc); end
  endtask

  task automatic test_wrap();
    logic [15:0] ad; int rd, iw, dn; bit st;
    bus.pcw = 1'b1; bus.pc_in = 16'hFFFE; tick(); bus.pcw = 1'b0;
    m_pc = 16'hFFFE;
    total++; if (bus.pc !== m_pc) begin bad++; $display("FAIL wrap_pcw got=%h exp=%h", bus.pc, m_pc); end
    drive_txn(1'b1, 1'b0, 16'h0000, 3, 16'hE017, 1'b0, 16'h0000, 1'b0, ad, rd, iw, dn, st);
    m_md = 16'hE017; m_pc = 16'h0000;
    total++; if (ad !== 16'hFFFE) begin bad++; $display("FAIL wrap_addr got=%h exp=fffe", ad); end
    total++; if (rd != 4) begin bad++; $display("FAIL wrap_rd_cycles got=%0d exp=4", rd); end
    total++; if (bus.md !== m_md) begin bad++; $display("FAIL wrap_md got=%h exp=%h", bus.md, m_md); end
    total++; if (bus.pc !== m_pc) begin bad++; $display("FAIL wrap_pc got=%h exp=%h", bus.pc, m_pc); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL wrap_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_collision();
    logic [15:0] ad; int rd, iw, dn; bit st;
    logic [15:0] pc0;
    pc0 = m_pc;
    drive_txn(1'b1, 1'b1, 16'h0040, 1, 16'h5A5A, 1'b0, 16'h0000, 1'b0, ad, rd, iw, dn, st);
    m_md = 16'h5A5A; m_pc = pc0 + 16'd2;
    total++; if (ad !== pc0) begin bad++; $display("FAIL coll_addr got=%h exp=%h", ad, pc0); end
    total++; if (iw != 1 || rd != 2) begin bad++; $display("FAIL coll_fetch got iw=%0d rd=%0d exp=1/2", iw, rd); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL coll_load_dropped busy=%b exp=0", bus.busy); end
    drive_txn(1'b0, 1'b1, 16'h0040, 2, 16'hC3C3, 1'b0, 16'h0000, 1'b0, ad, rd, iw, dn, st);
    m_md = 16'hC3C3;
    total++; if (ad !== 16'h0040) begin bad++; $display("FAIL load_addr got=%h exp=0040", ad); end
    total++; if (iw != 0 || dn != 1) begin bad++; $display("FAIL load_pulses got iw=%0d done=%0d exp=0/1", iw, dn); end
    total++; if (bus.md !== m_md) begin bad++; $display("FAIL load_md got=%h exp=%h", bus.md, m_md); end
    total++; if (bus.pc !== m_pc) begin bad++; $display("FAIL load_pc got=%h exp=%h", bus.pc, m_pc); end
  endtask

  task automatic test_pcw_coincident();
    logic [15:0] ad; int rd, iw, dn; bit st;
    drive_txn(1'b1, 1'b0, 16'h0000, 2, 16'h7E11, 1'b1, 16'h0100, 1'b0, ad, rd, iw, dn, st);
    m_md = 16'h7E11; m_pc = 16'h0100;
    total++; if (bus.pc !== m_pc) begin bad++; $display("FAIL pcw_ack_pc got=%h exp=%h", bus.pc, m_pc); end
    total++; if (bus.md !== m_md) begin bad++; $display("FAIL pcw_ack_md got=%h exp=%h", bus.md, m_md); end
    total++; if (iw != 1) begin bad++; $display("FAIL pcw_ack_iw got=%0d exp=1", iw); end
  endtask

  task automatic test_back_to_back();
    bus.fetch = 1'b1; tick();
    bus.fetch = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 16'h1111; tick();
    total++; if (bus.iw !== 1'b1 || bus.done !== 1'b1) begin bad++; $display("FAIL b2b_first_pulse got iw=%b done=%b exp=1/1", bus.iw, bus.done); end
    bus.fetch = 1'b1; bus.mem_ack = 1'b0; tick();
    total++; if (bus.busy !== 1'b1 || bus.mem_addr !== m_pc + 16'd2) begin
      bad++; $display("FAIL b2b_second_accept got busy=%b addr=%h exp=1/%h", bus.busy, bus.mem_addr, m_pc + 16'd2);
    end
    total++; if (bus.iw !== 1'b0) begin bad++; $display("FAIL b2b_iw_cleared got=%b exp=0", bus.iw); end
    bus.fetch = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 16'h2222; tick();
    bus.mem_ack = 1'b0; tick();
    m_pc = m_pc + 16'd4; m_md = 16'h2222;
    total++; if (bus.pc !== m_pc || bus.md !== m_md) begin bad++; $display("FAIL b2b_final got pc=%h md=%h exp=%h/%h", bus.pc, bus.md, m_pc, m_md); end
  endtask

  task automatic test_idle_ack();
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hDEAD; tick();
    bus.mem_ack = 1'b0; tick();
    total++; if (bus.md !== m_md || bus.pc !== m_pc) begin bad++; $display("FAIL idle_ack got md=%h pc=%h exp=%h/%h", bus.md, bus.pc, m_md, m_pc); end
    total++; if ({bus.iw, bus.done, bus.busy} !== 3'b000) begin bad++; $display("FAIL idle_ack_flags got=%b exp=000", {bus.iw, bus.done, bus.busy}); end
  endtask

  task automatic test_timeout();
    logic [15:0] ad; int rd, iw, dn; bit st;
    drive_txn(1'b1, 1'b0, 16'h0000, 15, 16'h0F0F, 1'b0, 16'h0000, 1'b0, ad, rd, iw, dn, st);
    m_md = 16'h0F0F; m_pc = m_pc + 16'd2;
    total++; if (rd != 16 || iw != 1) begin bad++; $display("FAIL late_ack got rd=%0d iw=%0d exp=16/1", rd, iw); end
    total++; if (bus.fault !== 1'b0) begin bad++; $display("FAIL late_ack_fault got=%b exp=0", bus.fault); end
    drive_txn(1'b1, 1'b0, 16'h0000, 16, 16'h0000, 1'b0, 16'h0000, 1'b0, ad, rd, iw, dn, st);
    m_fault = 1'b1;
    total++; if (rd != 16) begin bad++; $display("FAIL tmo_rd_cycles got=%0d exp=16", rd); end
    total++; if (iw != 0 || dn != 0) begin bad++; $display("FAIL tmo_pulses got iw=%0d done=%0d exp=0/0", iw, dn); end
    total++; if (bus.fault !== 1'b1) begin bad++; $display("FAIL tmo_fault got=%b exp=1", bus.fault); end
    total++; if (bus.md !== m_md || bus.pc !== m_pc) begin bad++; $display("FAIL tmo_state got md=%h pc=%h exp=%h/%h", bus.md, bus.pc, m_md, m_pc); end
    drive_txn(1'b1, 1'b0, 16'h0000, 1, 16'hABCD, 1'b0, 16'h0000, 1'b0, ad, rd, iw, dn, st);
    m_md = 16'hABCD; m_pc = m_pc + 16'd2;
    total++; if (bus.md !== m_md || iw != 1 || bus.fault !== 1'b1) begin
      bad++; $display("FAIL post_tmo got md=%h iw=%0d fault=%b exp=%h/1/1", bus.md, iw, bus.fault, m_md);
    end
  endtask

  task automatic test_random();
    logic [15:0] ad, exp_ad, a, d, pcv; int rd, iw, dn, w, kind; bit st, pw, ok;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        pcv = 16'($urandom); bus.pcw = 1'b1; bus.pc_in = pcv; tick(); bus.pcw = 1'b0; m_pc = pcv;
      end
      kind = $urandom_range(0, 2);
      a = 16'($urandom); d = 16'($urandom); pcv = 16'($urandom);
      w = ($urandom_range(0, 9) == 0) ? 16 : $urandom_range(0, 6);
      pw = (w < 16) && ($urandom_range(0, 3) == 0);
      exp_ad = (kind == 1) ? a : m_pc;
      drive_txn(kind != 1, kind != 0, a, w, d, pw, pcv, 1'b1, ad, rd, iw, dn, st);
      ok = (w < 16);
      if (ok) m_md = d;
      if (pw) m_pc = pcv;
      else if (ok && kind != 1) m_pc = m_pc + 16'd2;
      if (!ok) m_fault = 1'b1;
      total++; if (ad !== exp_ad) begin bad++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, ad, exp_ad); end
      total++; if (rd != (ok ? w + 1 : 16)) begin bad++; $display("FAIL rnd_rd n=%0d got=%0d exp=%0d", n, rd, ok ? w + 1 : 16); end
      total++; if (iw != ((ok && kind != 1) ? 1 : 0) || dn != (ok ? 1 : 0)) begin
        bad++; $display("FAIL rnd_pulses n=%0d got iw=%0d done=%0d", n, iw, dn);
      end
      total++; if (!st) begin bad++; $display("FAIL rnd_addr_stable n=%0d got=0 exp=1", n); end
      total++; if (bus.md !== m_md || bus.pc !== m_pc || bus.fault !== m_fault) begin
        bad++; $display("FAIL rnd_state n=%0d got md=%h pc=%h fault=%b exp=%h/%h/%b", n, bus.md, bus.pc, bus.fault, m_md, m_pc, m_fault);
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.fetch = 1'b1; tick(); bus.fetch = 1'b0; tick(); tick();
    total++; if (bus.mem_rd !== 1'b1) begin bad++; $display("FAIL rmid_pre_rd got=%b exp=1", bus.mem_rd); end
    #2 rst = 1'b1;
    #1;
    total++; if (bus.mem_rd !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_async got rd=%b busy=%b exp=0/0", bus.mem_rd, bus.busy); end
    tick();
    rst = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hBEEF; tick();
    bus.mem_ack = 1'b0;
    m_pc = 16'h0000; m_md = 16'h0000; m_fault = 1'b0;
    total++; if (bus.md !== m_md || bus.pc !== m_pc || bus.mem_addr !== 16'h0000) begin
      bad++; $display("FAIL rmid_regs got md=%h pc=%h addr=%h exp=0000", bus.md, bus.pc, bus.mem_addr);
    end
    total++; if ({bus.mem_rd, bus.iw, bus.busy, bus.done, bus.fault} !== 5'b00000) begin
      bad++; $display("FAIL rmid_flags got=%b exp=00000", {bus.mem_rd, bus.iw, bus.busy, bus.done, bus.fault});
    end
    tick();
    total++; if (bus.iw !== 1'b0) begin bad++; $display("FAIL rmid_iw got=%b exp=0", bus.iw); end
  endtask

  initial begin
    bus.fetch = 1'b0; bus.load = 1'b0; bus.aluo = 16'h0000; bus.pcw = 1'b0;
    bus.pc_in = 16'h0000; bus.mem_ack = 1'b0; bus.mem_rdata = 16'h0000;
    test_reset();
    test_fetch_basic();
    test_wrap();
    test_collision();
    test_pcw_coincident();
    test_back_to_back();
    test_idle_ack();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_fetch_unit.md
MEM_FETCH_UNIT -- requirements
Module: mem_fetch_unit

Interface
REQ-001 Single clock CLK; reset RST asynchronous, active-high; all state clears on RST assertion without waiting for a clock edge.
REQ-002 CLK  input  1  system clock, rising-edge active.
REQ-003 RST  input  1  asynchronous active-high reset.
REQ-004 Fetch  input  1  instruction-fetch request, sampled on rising CLK.
REQ-005 Load  input  1  data-read request, sampled on rising CLK.
REQ-006 ALUO  input  16  data address for Load, captured when the request is accepted.
REQ-007 PCW  input  1  PC write enable.
REQ-008 PCIn  input  16  new PC value, loaded when PCW=1.
REQ-009 MemAck  input  1  memory read acknowledge; MemRData is valid in the same cycle.
REQ-010 MemRData  input  16  memory read data.
REQ-011 MemAddr  output  16  registered memory address.
REQ-012 MemRd  output  1  registered memory read strobe.
REQ-013 MD  output  16  memory data register; feeds IR/RF stage data input.
REQ-014 IW  output  1  one-cycle instruction-write pulse to IR.
REQ-015 PC  output  16  program counter.
REQ-016 Busy  output  1  high while a request is outstanding.
REQ-017 Done  output  1  one-cycle completion pulse, fetch or load.
REQ-018 Fault  output  1  sticky timeout flag.

Function
REQ-019 States: IDLE, IREQ (instruction read), DREQ (data read); Busy=1 exactly in IREQ/DREQ.
REQ-020 IDLE + Fetch=1 at edge k -> IREQ; from edge k: MemAddr=PC, MemRd=1.
REQ-021 IDLE + Load=1, Fetch=0 at edge k -> DREQ; from edge k: MemAddr=ALUO value sampled at edge k, MemRd=1.
REQ-022 Fetch and Load both high in IDLE: fetch accepted, Load dropped (not queued).
REQ-023 Fetch/Load while Busy=1: ignored, no queuing, no effect on the outstanding request.
REQ-024 MemAddr and MemRd held constant from acceptance until ack or timeout, regardless of PC, PCW or ALUO changes.
REQ-025 IREQ + MemAck=1 at edge m: MD<=MemRData, PC<=PC+2 (modulo 2^16; 0xFFFE -> 0x0000), IW=1 and Done=1 for exactly the cycle after edge m, MemRd=0, -> IDLE.
REQ-026 DREQ + MemAck=1 at edge m: MD<=MemRData, Done=1 for one cycle, IW stays 0, PC unchanged, MemRd=0, -> IDLE.
REQ-027 Minimum latency: request at edge k, ack at edge k+1, IW/Done high in cycle k+1..k+2; a new request is accepted at edge k+2 (back-to-back allowed while IW/Done high).
REQ-028 MemAck while IDLE: ignored, no register changes.
REQ-029 PCW=1 at any edge: PC<=PCIn; if coincident with fetch completion, PCIn wins over PC+2 (MD and IW still updated).
REQ-030 Timeout: 4-bit counter clears on acceptance, increments each cycle in IREQ/DREQ without MemAck; at the 16th edge without ack: MemRd=0, -> IDLE, Fault=1, no MD/PC/IW/Done change.
REQ-031 MemAck coincident with the 16th edge: counts as success, no Fault.
REQ-032 Fault stays 1 until RST; requests are still serviced while Fault=1.

Reset
REQ-033 RST=1: state IDLE, PC=0x0000, MD=0x0000, MemAddr=0x0000, MemRd=0, IW=0, Busy=0, Done=0, Fault=0, counter=0.
REQ-034 RST mid-request: MemRd falls asynchronously; a MemAck arriving after RST deasserts is ignored.

Verification
REQ-035 Reset, Fetch pulse, MemAck next cycle with MemRData=0x0127 -> MemAddr=0x0000, MD=0x0127, IW/Done one cycle, PC=0x0002.
REQ-036 PCW with PCIn=0xFFFE, Fetch, ack with data 0xE017 after 3 wait cycles -> MemRd high 4 cycles, MD=0xE017, PC=0x0000, Busy low after ack.
REQ-037 Fetch and Load with ALUO=0x0040 in the same cycle -> MemAddr=PC, IW pulse; Load dropped; then Load alone -> MemAddr=0x0040, MD=ack data, IW=0, PC unchanged.
REQ-038 Fetch, no MemAck for 16 cycles -> MemRd drops, Fault=1, MD/PC unchanged, no IW; next fetch with ack succeeds, Fault stays 1.
REQ-039 Fetch completes in the same cycle as PCW with PCIn=0x0100 -> PC=0x0100, MD updated, IW pulse.
REQ-040 RST asserted during IREQ, then late MemAck -> all outputs at reset values, MD=0x0000, no IW.
